// File: rtl/asrv32_stage_ctrl_pkg.sv
// asrv32_stage_ctrl_pkg: stage encodings, widths and opcode bit positions
// shared by the stage sequencer, LSU and CSR blocks.
`ifndef ASRV32_HEADER_VH
`define ASRV32_HEADER_VH
`define STAGE_WIDTH 3
`define FETCH_STAGE 3'd0
`define DECODE_STAGE 3'd1
`define EXECUTE_STAGE 3'd2
`define MEMORYACCESS_STAGE 3'd3
`define WRITEBACK_STAGE 3'd4
`define OPCODE_WIDTH 11
`define RTYPE 0
`define ITYPE 1
`define LOAD 2
`define STORE 3
`define BRANCH 4
`define JAL 5
`define JALR 6
`define LUI 7
`define AUIPC 8
`define SYSTEM 9
`define FENCE 10
`endif

package asrv32_stage_ctrl_pkg;

  localparam int STAGE_W  = `STAGE_WIDTH;
  localparam int OPCODE_W = `OPCODE_WIDTH;
  localparam int OP_LOAD  = `LOAD;
  localparam int OP_STORE = `STORE;

  typedef enum logic [STAGE_W-1:0] {
    ST_FETCH        = `FETCH_STAGE,
    ST_DECODE       = `DECODE_STAGE,
    ST_EXECUTE      = `EXECUTE_STAGE,
    ST_MEMORYACCESS = `MEMORYACCESS_STAGE,
    ST_WRITEBACK    = `WRITEBACK_STAGE
  } stage_e;

endpackage

// File: rtl/asrv32_wait_timer.sv
// asrv32_wait_timer: clearable saturating wait counter with a terminal
// count flag at LIMIT-1 (LIMIT=0 never flags).
// Ports: clk_i, rst_i (async high), clr_i, inc_i in; tc_o out.
module asrv32_wait_timer #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CW =
    (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TC  = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (LIMIT != 0) && (cnt_q == CNT_TC);

endmodule

// File: rtl/asrv32_stage_ctrl.sv
// asrv32_stage_ctrl: multicycle stage sequencer with memory handshakes,
// stall/flush, optional MEMORYACCESS skip, ack timeout, instret count.
// In:  i_clk, i_rst (async high), i_opcode (one-hot), i_imem_ack,
//      i_dmem_ack, i_stall, i_flush.
// Out: o_stage_q, per-stage enables, o_csr_stage_en, o_imem_req,
//      o_dmem_req, o_done_tick, o_instret, o_mem_timeout.
module asrv32_stage_ctrl
  import asrv32_stage_ctrl_pkg::*;
#(
  parameter bit          SKIP_MEM_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned INSTRET_W      = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [OPCODE_W-1:0]  i_opcode,
  input  logic                 i_imem_ack,
  input  logic                 i_dmem_ack,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic [STAGE_W-1:0]   o_stage_q,
  output logic                 o_fetch_stage_en,
  output logic                 o_decode_stage_en,
  output logic                 o_alu_stage_en,
  output logic                 o_memoryaccess_stage_en,
  output logic                 o_writeback_stage_en,
  output logic                 o_csr_stage_en,
  output logic                 o_imem_req,
  output logic                 o_dmem_req,
  output logic                 o_done_tick,
  output logic [INSTRET_W-1:0] o_instret,
  output logic                 o_mem_timeout
);

  stage_e               stage_q;
  stage_e               stage_d;
  logic                 tmo_q;
  logic                 tmo_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;
  logic                 wait_inc;
  logic                 wait_clr;
  logic                 wait_tc;
  logic                 mem_op;
  logic                 skip_path;
  logic                 op_unused;

  assign mem_op    = i_opcode[OP_LOAD] | i_opcode[OP_STORE];
  assign skip_path = SKIP_MEM_EN & ~mem_op;
  assign op_unused = ^i_opcode;

  // Flush beats stall; stall freezes everything; a timeout only
  // fires on a cycle that would otherwise keep waiting.
  always_comb begin
    stage_d  = stage_q;
    tmo_d    = 1'b0;
    wait_inc = 1'b0;
    retire   = 1'b0;
    if (i_flush) begin
      stage_d = ST_FETCH;
    end else if (!i_stall) begin
      case (stage_q)
        ST_FETCH: begin
          if (i_imem_ack) begin
            stage_d = ST_DECODE;
          end else if (wait_tc) begin
            tmo_d = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
        ST_DECODE: stage_d = ST_EXECUTE;
        ST_EXECUTE: begin
          stage_d = skip_path ? ST_WRITEBACK
                              : ST_MEMORYACCESS;
        end
        ST_MEMORYACCESS: begin
          if (!mem_op || i_dmem_ack) begin
            stage_d = ST_WRITEBACK;
          end else if (wait_tc) begin
            stage_d = ST_FETCH;
            tmo_d   = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
        ST_WRITEBACK: begin
          stage_d = ST_FETCH;
          retire  = 1'b1;
        end
        default: stage_d = ST_FETCH;
      endcase
    end
  end

  // A timeout in FETCH keeps the stage, so clear explicitly too.
  assign wait_clr = i_flush | tmo_d | (stage_d != stage_q);

  asrv32_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .clr_i(wait_clr),
    .inc_i(wait_inc),
    .tc_o (wait_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stage_q   <= ST_FETCH;
      tmo_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign o_stage_q               = stage_q;
  assign o_fetch_stage_en        = (stage_q == ST_FETCH);
  assign o_decode_stage_en       = (stage_q == ST_DECODE);
  assign o_alu_stage_en          = (stage_q == ST_EXECUTE);
  assign o_memoryaccess_stage_en = (stage_q == ST_MEMORYACCESS);
  assign o_writeback_stage_en    = (stage_q == ST_WRITEBACK);

  // CSR work rides EXECUTE when MEMORYACCESS is being skipped.
  assign o_csr_stage_en =
    (stage_q == ST_MEMORYACCESS) |
    ((stage_q == ST_EXECUTE) & skip_path);

  assign o_imem_req =
    (stage_q == ST_FETCH) & ~i_stall;
  assign o_dmem_req =
    (stage_q == ST_MEMORYACCESS) & mem_op & ~i_stall;
  assign o_done_tick   = retire;
  assign o_instret     = instret_q;
  assign o_mem_timeout = tmo_q;

endmodule

// File: tb/tb_asrv32_stage_ctrl.sv
// tb_asrv32_stage_ctrl: two sequencer instances (skip/16/64 and
// no-skip/4/4) on shared inputs, directed table plus random run.
module tb_asrv32_stage_ctrl;

  localparam logic [10:0] OR_ = 11'h001;
  localparam logic [10:0] OL_ = 11'h004;
  localparam logic [10:0] OS_ = 11'h008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] op  = OR_;
  logic        ia  = 1'b0;
  logic        da  = 1'b0;
  logic        st  = 1'b0;
  logic        fl  = 1'b0;

  logic [2:0]  s0, s1;
  logic        fe0, de0, ex0, ma0, wb0, csr0;
  logic        fe1, de1, ex1, ma1, wb1, csr1;
  logic        ireq0, dreq0, done0, tmo0;
  logic        ireq1, dreq1, done1, tmo1;
  logic [63:0] inst0;
  logic [3:0]  inst1;

  always #5 clk = ~clk;

  asrv32_stage_ctrl #(
    .SKIP_MEM_EN(1'b1), .TIMEOUT_CYCLES(16), .INSTRET_W(64)
  ) d0 (
    .i_clk(clk), .i_rst(rst), .i_opcode(op),
    .i_imem_ack(ia), .i_dmem_ack(da),
    .i_stall(st), .i_flush(fl),
    .o_stage_q(s0),
    .o_fetch_stage_en(fe0), .o_decode_stage_en(de0),
    .o_alu_stage_en(ex0), .o_memoryaccess_stage_en(ma0),
    .o_writeback_stage_en(wb0), .o_csr_stage_en(csr0),
    .o_imem_req(ireq0), .o_dmem_req(dreq0),
    .o_done_tick(done0), .o_instret(inst0),
    .o_mem_timeout(tmo0)
  );

  asrv32_stage_ctrl #(
    .SKIP_MEM_EN(1'b0), .TIMEOUT_CYCLES(4), .INSTRET_W(4)
  ) d1 (
    .i_clk(clk), .i_rst(rst), .i_opcode(op),
    .i_imem_ack(ia), .i_dmem_ack(da),
    .i_stall(st), .i_flush(fl),
    .o_stage_q(s1),
    .o_fetch_stage_en(fe1), .o_decode_stage_en(de1),
    .o_alu_stage_en(ex1), .o_memoryaccess_stage_en(ma1),
    .o_writeback_stage_en(wb1), .o_csr_stage_en(csr1),
    .o_imem_req(ireq1), .o_dmem_req(dreq1),
    .o_done_tick(done1), .o_instret(inst1),
    .o_mem_timeout(tmo1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t",
                  name, act, exp, $time);
  endtask

  // Reference model: stage numbers 0..4 as the rules describe them.
  int              m_s [2];
  int              m_w [2];
  longint unsigned m_ir[2];
  bit              m_t [2];

  function automatic longint unsigned irmask(int k);
    return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 0; m_w[k] = 0; m_ir[k] = 0; m_t[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit m;
    bit wt;
    int lim;
    m = op[2] | op[3];
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 16 : 4;
      m_t[k] = 0;
      if (fl) begin
        m_s[k] = 0; m_w[k] = 0;
      end else if (!st) begin
        wt = (m_s[k] == 0 && !ia) ||
             (m_s[k] == 3 && m && !da);
        if (wt) begin
          if (m_w[k] == lim - 1) begin
            m_s[k] = 0; m_w[k] = 0; m_t[k] = 1;
          end else begin
            m_w[k]++;
          end
        end else begin
          if (m_s[k] == 4) begin
            m_s[k] = 0;
            m_ir[k] = (m_ir[k] + 1) & irmask(k);
          end else if (m_s[k] == 2) begin
            m_s[k] = (k == 0 && !m) ? 4 : 3;
          end else if (m_s[k] == 3) begin
            m_s[k] = 4;
          end else begin
            m_s[k] = m_s[k] + 1;
          end
          m_w[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(int k);
    int s;
    bit m;
    bit sk;
    s  = m_s[k];
    m  = op[2] | op[3];
    sk = (k == 0) && !m;
    return {3'(s), s == 4, s == 3, s == 2, s == 1, s == 0,
            (s == 3) || (s == 2 && sk),
            s == 0 && !st, s == 3 && m && !st,
            s == 4 && !st && !fl, m_t[k]};
  endfunction

  function automatic logic [12:0] act_vec(int k);
    if (k == 0)
      return {s0, wb0, ma0, ex0, de0, fe0, csr0,
              ireq0, dreq0, done0, tmo0};
    return {s1, wb1, ma1, ex1, de1, fe1, csr1,
            ireq1, dreq1, done1, tmo1};
  endfunction

  task automatic apply(input logic [10:0] o,
                       input logic a, b, s, f);
    op = o; ia = a; da = b; st = s; fl = f;
    @(negedge clk);
    chk("d0 outputs", 64'(act_vec(0)), 64'(exp_vec(0)));
    chk("d0 instret", inst0, m_ir[0]);
    chk("d1 outputs", 64'(act_vec(1)), 64'(exp_vec(1)));
    chk("d1 instret", {60'd0, inst1}, m_ir[1]);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic [10:0] o,
                     input logic a, b, s, f);
    apply(o, a, b, s, f);
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op = OR_; ia = 0; da = 0; st = 0; fl = 0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    logic [10:0] op;
    bit          ia, da, st, fl;
    int          e0, e1;
    bit          dn0, dn1, t1;
    int          ir1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, logic [10:0] o,
                              bit a, bit b, bit s, bit f,
                              int e0, int e1, bit n0, bit n1,
                              bit t1, int ir1);
    vec_t v;
    v.rst = r; v.op = o; v.ia = a; v.da = b; v.st = s; v.fl = f;
    v.e0 = e0; v.e1 = e1; v.dn0 = n0; v.dn1 = n1;
    v.t1 = t1; v.ir1 = ir1;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ALU op, zero-wait acks
    add(1, OR_, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 0, 4, 0, 1, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, OR_, 1, 1, 0, 0, 2, 1, 0, 0, 0, 1);
    add(0, OR_, 1, 1, 0, 0, 4, 2, 1, 0, 0, 1);
    add(0, OR_, 1, 1, 0, 0, 0, 3, 0, 0, 0, 1);
    add(0, OR_, 1, 1, 0, 0, 1, 4, 0, 1, 0, 1);
    // LOAD, dmem ack 3 cycles late (ack on last allowed wait)
    add(1, OL_, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    add(0, OL_, 1, 1, 0, 0, 3, 3, 0, 0, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 4, 4, 1, 1, 0, 0);
    add(0, OL_, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // two-cycle stall in EXECUTE
    add(1, OR_, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 1, 0, 2, 2, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 1, 0, 2, 2, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 0, 4, 0, 1, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    // flush: d1 in WRITEBACK, d0 in FETCH with ack
    add(1, OR_, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 2, 2, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 1, 0, 4, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OR_, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    // imem ack never: d1 times out every 4 cycles
    add(1, OR_, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 10; i++)
      add(0, OR_, 0, 0, 0, 0, 0, 0, 0, 0,
          (i == 4 || i == 8), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].op, tbl[i].ia, tbl[i].da,
            tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl%0d d0 stage", i),
          64'(s0), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d d1 stage", i),
          64'(s1), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d done", i),
          {62'd0, done0, done1}, {62'd0, tbl[i].dn0, tbl[i].dn1});
      chk($sformatf("tbl%0d d1 timeout", i),
          64'(tmo1), 64'(tbl[i].t1));
      chk($sformatf("tbl%0d d1 instret", i),
          64'(inst1), 64'(tbl[i].ir1));
      adv();
    end

    // instret wrap on the 4-bit instance
    do_reset();
    repeat (75) cyc(OR_, 1, 1, 0, 0);
    apply(OR_, 1, 1, 0, 0);
    chk("instret1 at max", 64'(inst1), 64'd15);
    adv();
    repeat (4) cyc(OR_, 1, 1, 0, 0);
    apply(OR_, 1, 1, 0, 0);
    chk("instret1 wrapped", 64'(inst1), 64'd0);
    chk("instret0 count", inst0, 64'd20);
    adv();

    // async reset while both sit in MEMORYACCESS
    for (int i = 0; i < 8; i++) begin
      if (s1 == 3'd3) break;
      cyc(OL_, 1, 0, 0, 0);
    end
    chk("d1 reached memacc", 64'(s1), 64'd3);
    chk("d0 reached memacc", 64'(s0), 64'd3);
    rst = 1'b1;
    #1;
    chk("async rst d0 stage", 64'(s0), 64'd0);
    chk("async rst d1 stage", 64'(s1), 64'd0);
    chk("async rst d0 instret", inst0, 64'd0);
    chk("async rst flags",
        {60'd0, tmo0, tmo1, done0, done1}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      logic [10:0] o;
      int r;
      o = op;
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0) o = OL_;
        else if (r == 1) o = OS_;
        else o = 11'(1) << $urandom_range(0, 10);
      end
      cyc(o,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
